mult_reg_sequencer: RTL and testbench

//   Parametrised shift-add multiplier datapath with its own sequencer. Holds X (sign/carry), A (upper product)
//   and B (multiplier / lower product), contains the WIDTH+1-bit add/subtract unit and a bit counter.

---
 rtl/mult_reg_sequencer_if.sv | 44 ++++
 rtl/mult_reg_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mult_reg_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_reg_sequencer_if.sv
// Bus bundle between the switch/button front end and the multiplier datapath.
// The master drives operands and controls; the slave returns status and product.
interface mult_reg_sequencer_if #(
  parameter int WIDTH = 8
);

  // Controls and operand from the front end
  logic             Ld_B;
  logic             Start;
  logic             Signed_Mode;
  logic [WIDTH-1:0] Switch_D;

  // Status and product back to the display drivers
  logic             Busy;
  logic             Done;
  logic             X;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;

  modport master (
    output Ld_B,
    output Start,
    output Signed_Mode,
    output Switch_D,
    input  Busy,
    input  Done,
    input  X,
    input  A,
    input  B
  );

  modport slave (
    input  Ld_B,
    input  Start,
    input  Signed_Mode,
    input  Switch_D,
    output Busy,
    output Done,
    output X,
    output A,
    output B
  );

endinterface

// File: rtl/mult_reg_sequencer.sv
// Shift-add multiplier datapath with its own sequencer.
// State word is {X, A, B}: X is the extension bit, A the upper product half,
// B starts as the multiplier and ends as the lower product half. S holds the
// multiplicand latched at start. Signed runs subtract S on the final bit so the
// multiplier's sign bit carries negative weight (two's complement).
module mult_reg_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mult_reg_sequencer_if.slave   bus
);

  // Counter wide enough to hold WIDTH-1 without wrapping mid-run
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADD    = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Extend an operand to WIDTH+1 bits: sign-extend in signed mode, zero-extend otherwise
  function automatic logic [WIDTH:0] ext_fn(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // Architectural state
  logic [2:0]       state_q,      state_d;
  logic             x_q,          x_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic [WIDTH-1:0] s_q,          s_d;
  logic             mode_q,       mode_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             start_prev_q, start_prev_d;

  // Datapath intermediates
  logic             start_rise_s;
  logic             last_bit_s;
  logic             do_sub_s;
  logic [WIDTH:0]   ext_a_s;
  logic [WIDTH:0]   ext_s_s;
  logic [WIDTH:0]   sum_s;
  logic             xn_s;

  // Edge detect on Start plus add/subtract unit and shift-in bit
  always_comb begin
    start_rise_s = bus.Start & ~start_prev_q;
    last_bit_s   = (cnt_q == CNT_LAST);
    do_sub_s     = last_bit_s & mode_q;
    ext_a_s      = ext_fn(a_q, mode_q);
    ext_s_s      = ext_fn(s_q, mode_q);
    if (do_sub_s) begin
      sum_s = ext_a_s - ext_s_s;
    end else begin
      sum_s = ext_a_s + ext_s_s;
    end
    xn_s = mode_q & x_q;
  end

  // Next-state logic for the sequencer and datapath registers
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    a_d          = a_q;
    b_d          = b_q;
    s_d          = s_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    start_prev_d = bus.Start;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.Ld_B) begin
          // Load has priority; a coincident start edge is consumed and dropped
          b_d = bus.Switch_D;
          a_d = {WIDTH{1'b0}};
          x_d = 1'b0;
        end else if (start_rise_s) begin
          // B is kept so consecutive runs chain on the previous low half
          s_d     = bus.Switch_D;
          mode_d  = bus.Signed_Mode;
          a_d     = {WIDTH{1'b0}};
          x_d     = 1'b0;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum_s;
        end else begin
          x_d = x_q;
          a_d = a_q;
        end
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        {x_d, a_d, b_d} = {xn_s, x_q, a_q, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (last_bit_s) begin
          // Product complete: drop Busy and raise Done together for the FINISH cycle
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_ADD;
        end
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        // Wait for Start to be released so a held button cannot retrigger
        busy_d = 1'b0;
        if (!bus.Start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      x_q          <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      s_q          <= {WIDTH{1'b0}};
      mode_q       <= 1'b0;
      cnt_q        <= CNT_ZERO;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_q          <= s_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= start_prev_d;
    end
  end

  // Outputs come straight from registers
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.X    = x_q;
  assign bus.A    = a_q;
  assign bus.B    = b_q;

endmodule

// File: tb/tb_mult_reg_sequencer.sv
// Self-checking bench for mult_reg_sequencer (WIDTH=8) with a product reference model.
module tb_mult_reg_sequencer;

  logic Clk;
  logic Reset;
  int   pass_cnt;
  int   chk_cnt;
  logic [7:0] b_model;

  mult_reg_sequencer_if #(.WIDTH(8)) bus ();

  mult_reg_sequencer #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: exact product of the two operands interpreted per mode
  function automatic logic [15:0] ref_prod(input logic [7:0] s, input logic [7:0] b, input logic sgn);
    int sv;
    int bv;
    sv = int'(s);
    bv = int'(b);
    if (sgn && s[7]) sv = sv - 256;
    if (sgn && b[7]) bv = bv - 256;
    return 16'(sv * bv);
  endfunction

  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    bus.Ld_B = 1'b1;
    bus.Switch_D = v;
    @(negedge Clk);
    bus.Ld_B = 1'b0;
    b_model = v;
  endtask

  // Drives one multiply; reports latency (-1 on timeout), result and Busy violations
  task automatic run_mult(input logic [7:0] s, input logic sgn, input bit scramble,
                          output int lat, output logic [7:0] a_o, output logic [7:0] b_o,
                          output logic x_o, output int busy_bad);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Switch_D = s;
    bus.Signed_Mode = sgn;
    bus.Ld_B = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin
        lat = c;
        if (bus.Busy !== 1'b0) busy_bad++;
        break;
      end
      if (bus.Busy !== 1'b1) busy_bad++;
      if (scramble) begin
        bus.Switch_D = 8'($urandom);
        bus.Signed_Mode = 1'($urandom);
        bus.Ld_B = 1'($urandom);
      end
    end
    a_o = bus.A;
    b_o = bus.B;
    x_o = bus.X;
    bus.Ld_B = 1'b0;
    bus.Start = 1'b0;
    bus.Switch_D = 8'h00;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk_cnt++;
    if ({bus.A, bus.B, bus.X, bus.Busy, bus.Done} !== 19'h0) begin
      $display("FAIL reset: A=%h B=%h X=%b Busy=%b Done=%b, required all zero",
               bus.A, bus.B, bus.X, bus.Busy, bus.Done);
    end else pass_cnt++;
    Reset = 1'b0;
    b_model = 8'h00;
    @(negedge Clk);
  endtask

  task automatic test_vector(input string name, input logic [7:0] bv, input bit do_load,
                             input logic [7:0] sv, input logic sgn,
                             input logic [15:0] exp_p, input logic exp_x);
    int lat, bb;
    logic [7:0] a, b;
    logic x;
    if (do_load) load_b(bv);
    run_mult(sv, sgn, 1'b0, lat, a, b, x, bb);
    b_model = exp_p[7:0];
    chk_cnt++;
    if (lat !== 17) $display("FAIL %s latency: got %0d, required 17", name, lat);
    else pass_cnt++;
    chk_cnt++;
    if ({x, a, b} !== {exp_x, exp_p}) begin
      $display("FAIL %s product: got X=%b A=%h B=%h, required X=%b A=%h B=%h",
               name, x, a, b, exp_x, exp_p[15:8], exp_p[7:0]);
    end else pass_cnt++;
    chk_cnt++;
    if (bb !== 0) $display("FAIL %s busy: %0d bad Busy samples, required 0", name, bb);
    else pass_cnt++;
  endtask

  task automatic test_ldb_start_priority;
    int bad;
    bad = 0;
    @(negedge Clk);
    bus.Ld_B = 1'b1;
    bus.Start = 1'b1;
    bus.Switch_D = 8'h5A;
    @(negedge Clk);
    bus.Ld_B = 1'b0;
    bus.Switch_D = 8'h11;
    for (int c = 0; c < 20; c++) begin
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) bad++;
      @(negedge Clk);
    end
    bus.Start = 1'b0;
    b_model = 8'h5A;
    chk_cnt++;
    if (bad !== 0) $display("FAIL ldb_start run: %0d cycles with Busy/Done, required 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.A, bus.B, bus.X} !== {8'h00, 8'h5A, 1'b0}) begin
      $display("FAIL ldb_start load: A=%h B=%h X=%b, required A=00 B=5a X=0", bus.A, bus.B, bus.X);
    end else pass_cnt++;
    @(negedge Clk);
  endtask

  task automatic test_reset_abort;
    int dones;
    dones = 0;
    load_b(8'h37);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Switch_D = 8'h9B;
    bus.Signed_Mode = 1'b1;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    bus.Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    chk_cnt++;
    if ({bus.A, bus.B, bus.X, bus.Busy, bus.Done} !== 19'h0) begin
      $display("FAIL reset_abort: A=%h B=%h X=%b Busy=%b Done=%b, required all zero",
               bus.A, bus.B, bus.X, bus.Busy, bus.Done);
    end else pass_cnt++;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) dones++;
    end
    chk_cnt++;
    if (dones !== 0) $display("FAIL reset_abort done: %0d active cycles, required 0", dones);
    else pass_cnt++;
    b_model = 8'h00;
  endtask

  task automatic test_hold;
    int seen, lat, act;
    seen = 0;
    act = 0;
    load_b(8'h0D);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Switch_D = 8'h0B;
    bus.Signed_Mode = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) seen++;
      if (seen > 0 && bus.Done !== 1'b1 && bus.Busy !== 1'b0) act++;
    end
    chk_cnt++;
    if (seen !== 1) $display("FAIL hold done count: got %0d, required 1", seen);
    else pass_cnt++;
    chk_cnt++;
    if (act !== 0) $display("FAIL hold restart: %0d busy cycles, required 0", act);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.A, bus.B} !== 16'd143) $display("FAIL hold product: got %h, required 008f", {bus.A, bus.B});
    else pass_cnt++;
    bus.Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    bus.Start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk_cnt++;
    if (lat !== 17 || {bus.A, bus.B} !== 16'd1573) begin
      $display("FAIL hold rerun: latency %0d product %h, required 17 and 0625", lat, {bus.A, bus.B});
    end else pass_cnt++;
    bus.Start = 1'b0;
    b_model = 8'h25;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_random;
    int lat, bb;
    logic [7:0] a, b, sv;
    logic x, sgn;
    logic [15:0] p;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
      sv = 8'($urandom);
      sgn = 1'($urandom);
      p = ref_prod(sv, b_model, sgn);
      run_mult(sv, sgn, 1'b1, lat, a, b, x, bb);
      chk_cnt++;
      if ({x, a, b} !== {sgn & p[15], p} || lat !== 17 || bb !== 0) begin
        $display("FAIL random %0d: S=%h Bin=%h sgn=%b got X=%b A=%h B=%h lat=%0d busybad=%0d, required X=%b P=%h lat=17",
                 i, sv, b_model, sgn, x, a, b, lat, bb, sgn & p[15], p);
      end else pass_cnt++;
      b_model = p[7:0];
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt = 0;
    Reset = 1'b1;
    bus.Ld_B = 1'b0;
    bus.Start = 1'b0;
    bus.Signed_Mode = 1'b0;
    bus.Switch_D = 8'h00;
    b_model = 8'h00;
    test_reset();
    test_vector("signed_neg", 8'h07, 1'b1, 8'hC5, 1'b1, 16'hFE63, 1'b1);
    test_vector("chain", 8'h00, 1'b0, 8'h02, 1'b1, 16'h00C6, 1'b0);
    test_vector("signed_min", 8'h80, 1'b1, 8'h80, 1'b1, 16'h4000, 1'b0);
    test_vector("unsigned_ff", 8'hFF, 1'b1, 8'hFF, 1'b0, 16'hFE01, 1'b0);
    test_vector("signed_ff", 8'hFF, 1'b1, 8'hFF, 1'b1, 16'h0001, 1'b0);
    test_ldb_start_priority();
    test_reset_abort();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
